// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle between the operand source, the logic unit and the result consumer.
// The slave modport is the unit's view; master is the source/consumer side.
interface logic_unit_pipe_if #(
    parameter int N    = 8,
    parameter int CNTW = 16
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [N-1:0]    A;
    logic [N-1:0]    B;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    Y;
    logic            zero;
    logic            ones;
    logic            parity;
    logic            ovf;
    logic [CNTW-1:0] op_count;

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, Y, zero, ones, parity, ovf, op_count
    );

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, Y, zero, ones, parity, ovf, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Single-stage pipelined N-bit bitwise logic unit with status flags and a
// completed-transaction counter.
//
// state | meaning
// EMPTY | no result held, out_valid=0, always ready for a new op
// FULL  | result and flags held in Y, out_valid=1, waiting for out_ready
module logic_unit_pipe #(
    parameter int N    = 8,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_pipe_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    state_t       state;
    logic         accept;
    logic         drain;
    logic [N-1:0] y_next;
    logic         ovf_next;

    assign bus.in_ready  = (state == EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = (state == FULL) && bus.out_ready;
    assign bus.out_valid = (state == FULL);

    always_comb begin
        y_next   = '0;
        ovf_next = 1'b0;
        case (bus.op)
            3'b000: y_next = ~bus.A;
            3'b001: y_next = bus.A & bus.B;
            3'b010: y_next = bus.A | bus.B;
            3'b011: y_next = bus.A ^ bus.B;
            3'b100: y_next = ~(bus.A & bus.B);
            3'b101: y_next = ~(bus.A | bus.B);
            3'b110: y_next = ~(bus.A ^ bus.B);
            default: begin
                // carry out of the increment is intentionally dropped
                y_next   = ~bus.A + {{(N-1){1'b0}}, 1'b1};
                ovf_next = (bus.A == MOST_NEG);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            bus.Y        <= '0;
            bus.zero     <= 1'b0;
            bus.ones     <= 1'b0;
            bus.parity   <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.op_count <= '0;
        end else begin
            if (drain)
                bus.op_count <= bus.op_count + {{(CNTW-1){1'b0}}, 1'b1};

            if (accept) begin
                bus.Y      <= y_next;
                bus.zero   <= ~|y_next;
                bus.ones   <= &y_next;
                bus.parity <= ^y_next;
                bus.ovf    <= ovf_next;
            end

            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (bus.out_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: stimulus pushes expected results, a
// negedge monitor pops and compares on every output handshake.
module tb_logic_unit_pipe;
    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.N(8), .CNTW(16)) bus ();
    logic_unit_pipe_if #(.N(8), .CNTW(4))  wbus ();

    logic_unit_pipe #(.N(8), .CNTW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic_unit_pipe #(.N(8), .CNTW(4)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    typedef struct packed {
        logic [7:0] y;
        logic       zero;
        logic       ones;
        logic       parity;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a handshake completes at the next posedge when both are high here.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {56'd0, bus.Y}, 64'hdead);
            end else begin
                e = exp_q.pop_front();
                chk("result", {59'd0, bus.Y, bus.zero, bus.ones, bus.parity, bus.ovf},
                    {59'd0, e});
            end
        end
    end

    task automatic push_exp(input logic [7:0] y, input logic ovf);
        exp_t e;
        e.y      = y;
        e.zero   = (y == 8'h00);
        e.ones   = (y == 8'hFF);
        e.parity = ^y;
        e.ovf    = ovf;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] y, input logic ovf);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.A  = a;
        bus.B  = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push_exp(y, ovf);
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       ovf;
    } vec_t;

    vec_t vecs[11] = '{
        '{3'b000, 8'hA5, 8'h3C, 8'h5A, 1'b0},
        '{3'b001, 8'hA5, 8'h3C, 8'h24, 1'b0},
        '{3'b010, 8'hA5, 8'h3C, 8'hBD, 1'b0},
        '{3'b011, 8'hA5, 8'h3C, 8'h99, 1'b0},
        '{3'b100, 8'hA5, 8'h3C, 8'hDB, 1'b0},
        '{3'b101, 8'hA5, 8'h3C, 8'h42, 1'b0},
        '{3'b110, 8'hA5, 8'h3C, 8'h66, 1'b0},
        '{3'b111, 8'hA5, 8'h3C, 8'h5B, 1'b0},
        '{3'b111, 8'h80, 8'h55, 8'h80, 1'b1},
        '{3'b111, 8'h00, 8'h55, 8'h00, 1'b0},
        '{3'b111, 8'h01, 8'h55, 8'hFF, 1'b0}
    };

    initial begin
        logic [15:0] cnt_before;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.op         = 3'b000;
        bus.A          = 8'h00;
        bus.B          = 8'h00;
        bus.out_ready  = 1'b1;
        wbus.in_valid  = 1'b0;
        wbus.op        = 3'b000;
        wbus.A         = 8'h00;
        wbus.B         = 8'h00;
        wbus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_y_flags", {52'd0, bus.Y, bus.zero, bus.ones, bus.parity, bus.ovf}, 64'd0);
        chk("rst_op_count", {48'd0, bus.op_count}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // all ops plus NEG boundaries, back to back
        @(posedge clk);
        #1;
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ovf);
        wait_drain();
        chk("op_count_after_ops", {48'd0, bus.op_count}, 64'd11);

        // backpressure
        bus.out_ready = 1'b0;
        issue(3'b011, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 3'b001;
            bus.A  = 8'(i * 17);
            bus.B  = 8'(8'hC3 ^ i);
            @(negedge clk);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_y_hold", {56'd0, bus.Y}, 64'hF0);
            @(posedge clk);
            #1;
        end
        cnt_before = bus.op_count;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_count_inc", {48'd0, bus.op_count}, {48'd0, cnt_before + 16'd1});
        chk("bp_empty_after", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // async reset while FULL and stalled
        bus.out_ready = 1'b0;
        issue(3'b000, 8'h0F, 8'h00, 8'hF0, 1'b0);
        bus.in_valid = 1'b0;
        chk("pre_rst_full", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_y_flags", {52'd0, bus.Y, bus.zero, bus.ones, bus.parity, bus.ovf}, 64'd0);
        chk("async_rst_op_count", {48'd0, bus.op_count}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // streaming NOT of an incrementing A
        for (int i = 0; i < 10; i++) issue(3'b000, 8'(i), 8'h00, 8'(8'hFF - i), 1'b0);
        wait_drain();
        chk("stream_op_count", {48'd0, bus.op_count}, 64'd10);

        // counter wrap on the 4-bit instance
        wbus.in_valid  = 1'b1;
        wbus.out_ready = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        wbus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_op_count", {60'd0, wbus.op_count}, 64'd1);
        chk("wrap_out_valid", {63'd0, wbus.out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
